// File: rtl/toggle_request_scheduler.sv
// Round-robin scheduler that turns queued per-channel toggle requests into isolated tog_en pulses.
// Latency: a req sampled at edge k yields tog_en at the earliest after edge k+1; each pulse lasts one cycle.
// Backpressure: hold=1 stops new pulses while queuing continues; a saturated channel drops its req and sets ovf.
module toggle_request_scheduler #(
  parameter int Width = 4,
  parameter int CntW  = 4,
  parameter int Gap   = 0
) (
  input  logic             clk,
  input  logic             ares_L,
  input  logic [Width-1:0] req,
  input  logic             hold,
  input  logic             clr_ovf,
  output logic [Width-1:0] tog_en,
  output logic             busy,
  output logic [Width-1:0] ovf
);

  localparam int PtrW = (Width > 1) ? $clog2(Width) : 1;
  localparam int GcW  = (Gap > 1) ? $clog2(Gap) : 1;
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  typedef enum logic {ST_IDLE, ST_GAP} state_t;

  state_t          state;
  logic [GcW-1:0]  gcnt;
  logic [PtrW-1:0] ptr;
  logic [CntW-1:0] cnt [Width];

  logic             found;
  logic [PtrW-1:0]  winner;
  logic [PtrW-1:0]  idx;
  logic             grant_vld;
  logic [Width-1:0] grant;
  logic [Width-1:0] ovf_set;
  logic             any_pend;

  // Pick the first channel with a nonzero registered count, scanning from ptr with wrap.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < Width; k++) begin
      idx = PtrW'((int'(ptr) + k) % Width);
      if (!found && cnt[idx] != '0) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Grant only from IDLE when not held; derive overflow events and the pending summary.
  always_comb begin
    grant_vld = (state == ST_IDLE) && !hold && found;
    grant     = grant_vld ? (Width'(1) << winner) : '0;
    ovf_set   = '0;
    any_pend  = 1'b0;
    for (int i = 0; i < Width; i++) begin
      ovf_set[i] = req[i] && !grant[i] && (cnt[i] == CntMax);
      if (cnt[i] != '0) any_pend = 1'b1;
    end
  end

  // Pending counters: +1 on req, -1 on grant, both cancel; a full counter holds and flags overflow.
  always_ff @(posedge clk or negedge ares_L) begin
    if (!ares_L) begin
      for (int i = 0; i < Width; i++) cnt[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < Width; i++) begin
        if (req[i] && !grant[i]) begin
          if (cnt[i] != CntMax) cnt[i] <= cnt[i] + 1'b1;
        end else if (!req[i] && grant[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
      // A new overflow event wins over a same-cycle clear.
      ovf <= (clr_ovf ? '0 : ovf) | ovf_set;
    end
  end

  // Issue FSM: registered one-hot pulse from IDLE, then Gap forced idle cycles in GAP.
  always_ff @(posedge clk or negedge ares_L) begin
    if (!ares_L) begin
      state  <= ST_IDLE;
      gcnt   <= '0;
      ptr    <= '0;
      tog_en <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tog_en <= grant;
          if (grant_vld) begin
            ptr <= PtrW'((int'(winner) + 1) % Width);
            if (Gap > 0) begin
              state <= ST_GAP;
              gcnt  <= GcW'(Gap - 1);
            end
          end
        end
        ST_GAP: begin
          tog_en <= '0;
          if (gcnt == '0) state <= ST_IDLE;
          else            gcnt  <= gcnt - 1'b1;
        end
        default: begin
          state  <= ST_IDLE;
          tog_en <= '0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE) || any_pend;

endmodule

// File: tb/tb_toggle_request_scheduler.sv
// Bench for toggle_request_scheduler: two instances (Gap=0/CntW=4 and Gap=2/CntW=2)
// checked every cycle against a queue-and-cooldown reference model, plus directed
// scenarios for single pulses, round-robin order, spacing, saturation and reset.
module tb_toggle_request_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            ares_L;
  logic [1:0][3:0] req;
  logic [1:0]      hold;
  logic [1:0]      clr;
  logic [1:0][3:0] tog;
  logic [1:0]      busy;
  logic [1:0][3:0] ovf;

  toggle_request_scheduler #(.Width(4), .CntW(4), .Gap(0)) dut0 (
    .clk(clk), .ares_L(ares_L), .req(req[0]), .hold(hold[0]), .clr_ovf(clr[0]),
    .tog_en(tog[0]), .busy(busy[0]), .ovf(ovf[0])
  );

  toggle_request_scheduler #(.Width(4), .CntW(2), .Gap(2)) dut1 (
    .clk(clk), .ares_L(ares_L), .req(req[1]), .hold(hold[1]), .clr_ovf(clr[1]),
    .tog_en(tog[1]), .busy(busy[1]), .ovf(ovf[1])
  );

  // Reference model: per-channel queue depth, next-start pointer, and a cooldown
  // counting cycles until the next pulse may be issued.
  int         pend [2][4];
  int         ptr  [2];
  int         cool [2];
  logic [3:0] m_tog [2];
  logic [3:0] m_ovf [2];
  int         pulses [2];
  int         gapv [2] = '{0, 2};
  int         maxv [2] = '{15, 3};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) pend[d][i] = 0;
      ptr[d]   = 0;
      cool[d]  = 0;
      m_tog[d] = 4'b0;
      m_ovf[d] = 4'b0;
    end
  endtask

  task automatic model_step(input int d);
    int win;
    int c;
    win = -1;
    if (cool[d] > 0) begin
      cool[d]--;
    end else if (!hold[d]) begin
      for (int k = 0; k < 4; k++) begin
        c = (ptr[d] + k) % 4;
        if (win < 0 && pend[d][c] > 0) win = c;
      end
    end
    m_tog[d] = (win >= 0) ? (4'b0001 << win) : 4'b0000;
    if (clr[d]) m_ovf[d] = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (req[d][i] && i != win) begin
        if (pend[d][i] == maxv[d]) m_ovf[d][i] = 1'b1;
        else pend[d][i]++;
      end else if (!req[d][i] && i == win) begin
        pend[d][i]--;
      end
    end
    if (win >= 0) begin
      ptr[d]  = (win + 1) % 4;
      cool[d] = gapv[d];
    end
  endtask

  function automatic logic model_busy(input int d);
    logic b;
    b = (cool[d] > 0);
    for (int i = 0; i < 4; i++) if (pend[d][i] > 0) b = 1'b1;
    return b;
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare just after it.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_tog%0d", tag, d), 32'(tog[d]), 32'(m_tog[d]));
      check($sformatf("%s_busy%0d", tag, d), 32'(busy[d]), 32'(model_busy(d)));
      check($sformatf("%s_ovf%0d", tag, d), 32'(ovf[d]), 32'(m_ovf[d]));
      if (tog[d] != 4'b0) pulses[d]++;
    end
  endtask

  task automatic clear_inputs();
    req  = '0;
    hold = '0;
    clr  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ares_L = 1'b0;
    model_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_tog%0d", d), 32'(tog[d]), 32'd0);
      check($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
      check($sformatf("rst_ovf%0d", d), 32'(ovf[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    ares_L = 1'b1;
  endtask

  int p0;

  initial begin
    clear_inputs();
    ares_L    = 1'b0;
    pulses[0] = 0;
    pulses[1] = 0;
    model_reset();

    // T1: single request on ch2, Gap=0
    do_reset();
    req[0] = 4'b0100;
    tick("t1");
    req[0] = 4'b0000;
    p0 = pulses[0];
    repeat (4) tick("t1");
    check("t1_pulses", 32'(pulses[0] - p0), 32'd1);
    check("t1_busy_end", 32'(busy[0]), 32'd0);

    // T2: three channels at once from ptr=0, back-to-back order 0,1,3
    do_reset();
    req[0] = 4'b1011;
    tick("t2");
    req[0] = 4'b0000;
    p0 = pulses[0];
    repeat (5) tick("t2");
    check("t2_pulses", 32'(pulses[0] - p0), 32'd3);

    // T3: Gap=2, three requests each on ch0 and ch1
    do_reset();
    p0 = pulses[1];
    req[1] = 4'b0011;
    repeat (3) tick("t3");
    req[1] = 4'b0000;
    repeat (25) tick("t3");
    check("t3_pulses", 32'(pulses[1] - p0), 32'd6);

    // T4: CntW=2 saturation under hold, then drain and clear overflow
    do_reset();
    hold[1] = 1'b1;
    req[1]  = 4'b0010;
    repeat (5) tick("t4");
    req[1] = 4'b0000;
    tick("t4");
    check("t4_ovf_set", 32'(ovf[1]), 32'h2);
    p0 = pulses[1];
    hold[1] = 1'b0;
    repeat (15) tick("t4");
    check("t4_pulses", 32'(pulses[1] - p0), 32'd3);
    clr[1] = 1'b1;
    tick("t4");
    clr[1] = 1'b0;
    check("t4_ovf_clr", 32'(ovf[1]), 32'h0);

    // T5: request on ch2 lands in the same cycle it is granted
    do_reset();
    p0 = pulses[0];
    req[0] = 4'b0100;
    repeat (2) tick("t5");
    req[0] = 4'b0000;
    repeat (4) tick("t5");
    check("t5_pulses", 32'(pulses[0] - p0), 32'd2);

    // Randomized traffic on both instances
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        req[d]  = 4'($urandom & $urandom);
        hold[d] = ($urandom_range(0, 3) == 0);
        clr[d]  = ($urandom_range(0, 19) == 0);
      end
      tick("rnd");
    end
    clear_inputs();
    repeat (60) tick("rnd_drain");

    // T6: asynchronous reset while in GAP with counts pending and ovf set
    do_reset();
    hold[1] = 1'b1;
    req[1]  = 4'b0100;
    repeat (4) tick("t6");
    hold[1] = 1'b0;
    req[1]  = 4'b0011;
    tick("t6");
    req[1] = 4'b0000;
    tick("t6");
    check("t6_pre_busy", 32'(busy[1]), 32'd1);
    check("t6_pre_ovf", 32'(ovf[1]), 32'h4);
    #2;
    ares_L = 1'b0;
    model_reset();
    #1;
    check("t6_tog", 32'(tog[1]), 32'd0);
    check("t6_busy", 32'(busy[1]), 32'd0);
    check("t6_ovf", 32'(ovf[1]), 32'd0);
    @(posedge clk);
    #1;
    ares_L = 1'b1;
    p0 = pulses[1];
    repeat (10) tick("t6_post");
    check("t6_no_pulses", 32'(pulses[1] - p0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
